// File: rtl/vga_timing_monitor.sv
// Passive VGA timing monitor: measures line, frame and sync-pulse lengths on the
// pixel strobe, tracks lock and sticky errors, and checksums the active area.
module vga_timing_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic        err_clr,
  output logic        locked,
  output logic        err_hline,
  output logic        err_hsync,
  output logic        err_frame,
  output logic        err_vsync,
  output logic [15:0] frame_cnt,
  output logic [23:0] frame_sum,
  output logic        frame_valid,
  output logic [1:0]  state_dbg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL = H_TOTAL * V_TOTAL;
  localparam int CW      = ($clog2(F_TOTAL + 1) > 19) ? $clog2(F_TOTAL + 1) : 19;

  localparam logic [CW-1:0] HT_C    = CW'(H_TOTAL);
  localparam logic [CW-1:0] FT_C    = CW'(F_TOTAL);
  localparam logic [CW-1:0] HSW_C   = CW'(H_SYNC);
  localparam logic [CW-1:0] VSW_C   = CW'(V_SYNC * H_TOTAL);
  localparam logic [CW-1:0] COL_LO  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] COL_HI  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] LINE_LO = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] LINE_HI = CW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          dirty, dirty_nx;
  logic          cnt_inc;
  logic          hs_q, vs_q, primed, hs_seen, vs_seen;
  logic [CW-1:0] h_cnt, hsw_cnt, f_cnt, vsw_cnt, line;
  logic [23:0]   acc;
  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic          e_hline, e_hsync, e_frame, e_vsync, any_err;
  logic          active;
  logic [23:0]   pix;

  // Counters hold at all-ones so a stuck sync can never wrap into a false match.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  assign hs_fall = pix_ce & ~hsync & hs_q;
  assign hs_rise = pix_ce & hsync & ~hs_q;
  assign vs_fall = pix_ce & ~vsync & vs_q;
  assign vs_rise = pix_ce & vsync & ~vs_q;

  // hs_seen/vs_seen only count edges taken after a real sample, so a sync that
  // is already low when reset releases never produces a measurement.
  assign e_hline = hs_fall & hs_seen & ((h_cnt + CW'(1)) != HT_C);
  assign e_hsync = hs_rise & hs_seen & (hsw_cnt != HSW_C);
  assign e_frame = vs_fall & vs_seen & ((f_cnt + CW'(1)) != FT_C);
  assign e_vsync = vs_rise & vs_seen & (vsw_cnt != VSW_C);
  assign any_err = e_hline | e_hsync | e_frame | e_vsync;

  assign active = (h_cnt >= COL_LO) && (h_cnt < COL_HI) &&
                  (line >= LINE_LO) && (line < LINE_HI);
  assign pix    = {12'd0, red, green, blue};

  assign locked    = (state == LOCKED);
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    dirty_nx = dirty;
    cnt_inc  = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nx = TRACK;
          dirty_nx = 1'b0;
        end
      end
      TRACK: begin
        if (vs_fall) begin
          if (!(dirty || any_err)) state_nx = LOCKED;
          dirty_nx = 1'b0;
        end else if (any_err) begin
          dirty_nx = 1'b1;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_nx = TRACK;
          dirty_nx = 1'b0;
        end else if (vs_fall) begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_nx = SEARCH;
        dirty_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      dirty     <= 1'b0;
      frame_cnt <= 16'd0;
      err_hline <= 1'b0;
      err_hsync <= 1'b0;
      err_frame <= 1'b0;
      err_vsync <= 1'b0;
    end else begin
      state     <= state_nx;
      dirty     <= dirty_nx;
      frame_cnt <= frame_cnt + {15'd0, cnt_inc};
      err_hline <= (err_hline & ~err_clr) | e_hline;
      err_hsync <= (err_hsync & ~err_clr) | e_hsync;
      err_frame <= (err_frame & ~err_clr) | e_frame;
      err_vsync <= (err_vsync & ~err_clr) | e_vsync;
    end
  end

  // frame_sum is qualified by frame_valid: a one-clk pulse, no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_sum   <= 24'd0;
      acc         <= 24'd0;
    end else begin
      frame_valid <= vs_fall & vs_seen;
      if (vs_fall && vs_seen) frame_sum <= acc;
      if (pix_ce) begin
        if (vs_fall)     acc <= active ? pix : 24'd0;
        else if (active) acc <= acc + pix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      primed  <= 1'b0;
      hs_seen <= 1'b0;
      vs_seen <= 1'b0;
      h_cnt   <= '0;
      hsw_cnt <= '0;
      f_cnt   <= '0;
      vsw_cnt <= '0;
      line    <= '0;
    end else if (pix_ce) begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      primed  <= 1'b1;
      if (hs_fall) hs_seen <= hs_seen | primed;
      if (vs_fall) vs_seen <= vs_seen | primed;
      h_cnt   <= hs_fall ? '0 : sat_inc(h_cnt);
      f_cnt   <= vs_fall ? '0 : sat_inc(f_cnt);
      hsw_cnt <= hsync ? '0 : sat_inc(hsw_cnt);
      vsw_cnt <= vsync ? '0 : sat_inc(vsw_cnt);
      if (vs_fall)      line <= '0;
      else if (hs_fall) line <= sat_inc(line);
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor in the 16x8 test mode: directed frames with
// per-sample capture for geometry/error checks and a frame_sum scoreboard.
module tb_vga_timing_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
  logic        err_clr;
  logic        locked;
  logic        err_hline, err_hsync, err_frame, err_vsync;
  logic [15:0] frame_cnt;
  logic [23:0] frame_sum;
  logic        frame_valid;
  logic [1:0]  state_dbg;

  vga_timing_monitor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .err_clr(err_clr), .locked(locked),
    .err_hline(err_hline), .err_hsync(err_hsync),
    .err_frame(err_frame), .err_vsync(err_vsync),
    .frame_cnt(frame_cnt), .frame_sum(frame_sum),
    .frame_valid(frame_valid), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          ce_div = 1;
  logic [23:0] exp_q[$];
  logic [23:0] prev_sum;
  logic        have_prev;
  logic [23:0] mon_exp;

  logic [3:0]  smp_err[0:255];
  logic        smp_lk[0:255];
  logic [15:0] smp_fc[0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_sample(input logic hs, input logic vs, input logic [11:0] rgb,
                             input logic clr);
    for (int i = 1; i < ce_div; i++) begin
      pix_ce  = 1'b0;
      err_clr = 1'b0;
      @(posedge clk); #1;
    end
    hsync = hs;
    vsync = vs;
    {red, green, blue} = rgb;
    err_clr = clr;
    pix_ce  = 1'b1;
    @(posedge clk); #1;
    pix_ce  = 1'b0;
    err_clr = 1'b0;
  endtask

  // One 8-line frame starting with the vs_fall sample; samples outside
  // [start_at, stop_at] are skipped so a frame can be split around a reset.
  task automatic send_frame(input logic [11:0] rgb, input int long_line, input int short_line,
                            input int vs_len, input int clr_at, input int hold_at,
                            input int start_at, input int stop_at);
    int s, len, pw;
    logic hs, vs;
    s = 0;
    if (start_at == 0) begin
      if (have_prev) exp_q.push_back(prev_sum);
      prev_sum  = {12'd0, rgb} << 5;
      have_prev = 1'b1;
    end
    for (int l = 0; l < 8; l++) begin
      len = (l == long_line) ? 17 : 16;
      pw  = (l == short_line) ? 2 : 3;
      for (int c = 0; c < len; c++) begin
        if (s >= start_at && s <= stop_at) begin
          hs = (c < pw) ? 1'b0 : 1'b1;
          vs = (s < vs_len) ? 1'b0 : 1'b1;
          if (s == hold_at) begin
            pix_ce = 1'b0;
            repeat (100) @(posedge clk);
            #1;
          end
          send_sample(hs, vs, rgb, s == clr_at);
          smp_err[s] = {err_hline, err_hsync, err_frame, err_vsync};
          smp_lk[s]  = locked;
          smp_fc[s]  = frame_cnt;
        end
        s++;
      end
    end
  endtask

  task automatic clean_frame(input logic [11:0] rgb);
    send_frame(rgb, -1, -1, 16, -1, -1, 0, 999);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_errs"}, {28'd0, err_hline, err_hsync, err_frame, err_vsync}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_frame_sum"}, {8'd0, frame_sum}, 32'd0);
    chk({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_sum unexpected frame_valid actual=%06h expected=none", frame_sum);
      end else begin
        mon_exp = exp_q.pop_front();
        if (frame_sum !== mon_exp) begin
          n_fail++;
          $display("FAIL frame_sum actual=%06h expected=%06h", frame_sum, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1;
    red = 4'd0; green = 4'd0; blue = 4'd0; err_clr = 1'b0;
    have_prev = 1'b0; prev_sum = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    #3 rst_n = 1'b1;

    // Nominal timing
    repeat (5) send_sample(1'b1, 1'b1, 12'h000, 1'b0);
    clean_frame(12'h123);
    chk("f1_locked", {31'd0, smp_lk[0]}, 32'd0);
    clean_frame(12'h123);
    chk("f2_locked", {31'd0, smp_lk[0]}, 32'd1);
    clean_frame(12'h123);
    clean_frame(12'h123);
    clean_frame(12'h123);
    chk("f5_frame_cnt", {16'd0, smp_fc[0]}, 32'd3);
    chk("f5_errs", {28'd0, smp_err[127]}, 32'd0);

    // Long line 5 while locked
    send_frame(12'hABC, 5, -1, 16, -1, -1, 0, 999);
    chk("f6_frame_cnt", {16'd0, smp_fc[0]}, 32'd4);
    chk("f6_locked_before", {31'd0, smp_lk[96]}, 32'd1);
    chk("f6_err_hline", {28'd0, smp_err[97]}, 32'h8);
    chk("f6_locked_after", {31'd0, smp_lk[97]}, 32'd0);
    clean_frame(12'h0F0);
    chk("f7_err_frame", {28'd0, smp_err[0]}, 32'hA);
    chk("f7_locked", {31'd0, smp_lk[0]}, 32'd0);
    clean_frame(12'hFFF);
    chk("f8_relock", {31'd0, smp_lk[0]}, 32'd1);
    chk("f8_frame_cnt", {16'd0, smp_fc[0]}, 32'd4);

    // err_clr alone
    send_frame(12'h123, -1, -1, 16, 20, -1, 0, 999);
    chk("f9_frame_cnt", {16'd0, smp_fc[0]}, 32'd5);
    chk("f9_errs_before_clr", {28'd0, smp_err[19]}, 32'hA);
    chk("f9_errs_after_clr", {28'd0, smp_err[20]}, 32'h0);
    chk("f9_locked_after_clr", {31'd0, smp_lk[20]}, 32'd1);

    // Short hsync pulse on line 2, vsync pulse of 15 samples
    send_frame(12'h555, -1, 2, 15, -1, -1, 0, 999);
    chk("f10_frame_cnt", {16'd0, smp_fc[0]}, 32'd6);
    chk("f10_locked_pre_vs", {31'd0, smp_lk[14]}, 32'd1);
    chk("f10_err_vsync", {28'd0, smp_err[15]}, 32'h1);
    chk("f10_locked_vs", {31'd0, smp_lk[15]}, 32'd0);
    chk("f10_pre_hsync", {28'd0, smp_err[33]}, 32'h1);
    chk("f10_err_hsync", {28'd0, smp_err[34]}, 32'h5);

    // err_clr coinciding with a new hline error
    send_frame(12'h321, 1, -1, 16, 33, -1, 0, 999);
    chk("f11_locked", {31'd0, smp_lk[0]}, 32'd0);
    chk("f11_errs_before", {28'd0, smp_err[32]}, 32'h5);
    chk("f11_clr_with_err", {28'd0, smp_err[33]}, 32'h8);
    clean_frame(12'h0A5);
    chk("f12_err_frame", {28'd0, smp_err[0]}, 32'hA);
    chk("f12_locked", {31'd0, smp_lk[0]}, 32'd0);
    send_frame(12'h123, -1, -1, 16, 5, -1, 0, 999);
    chk("f13_relock", {31'd0, smp_lk[0]}, 32'd1);
    chk("f13_frame_cnt", {16'd0, smp_fc[0]}, 32'd6);
    chk("f13_cleared", {28'd0, smp_err[5]}, 32'h0);

    // Strobe every 4th clk, with a 100-clk stall mid-frame
    ce_div = 4;
    send_frame(12'h123, -1, -1, 16, -1, 60, 0, 999);
    chk("f14_locked", {31'd0, smp_lk[0]}, 32'd1);
    chk("f14_frame_cnt", {16'd0, smp_fc[0]}, 32'd7);
    clean_frame(12'h123);
    chk("f15_frame_cnt", {16'd0, smp_fc[0]}, 32'd8);
    chk("f15_errs", {28'd0, smp_err[127]}, 32'h0);
    clean_frame(12'h7E1);
    chk("f16_frame_cnt", {16'd0, smp_fc[0]}, 32'd9);
    chk("f16_locked", {31'd0, smp_lk[127]}, 32'd1);
    ce_div = 1;

    // Reset in the middle of a frame, inside an hsync pulse
    send_frame(12'h123, -1, -1, 16, -1, -1, 0, 48);
    chk("f17_frame_cnt", {16'd0, smp_fc[0]}, 32'd10);
    rst_n = 1'b0;
    have_prev = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_frame(12'h123, -1, -1, 16, -1, -1, 49, 999);
    chk("partial_errs", {28'd0, smp_err[127]}, 32'h0);
    clean_frame(12'h321);
    chk("f18_locked", {31'd0, smp_lk[0]}, 32'd0);
    chk("f18_errs", {28'd0, smp_err[0]}, 32'h0);
    clean_frame(12'h3C3);
    chk("f19_locked", {31'd0, smp_lk[0]}, 32'd1);
    chk("f19_errs", {28'd0, smp_err[0]}, 32'h0);
    chk("f19_frame_cnt", {16'd0, smp_fc[0]}, 32'd0);
    clean_frame(12'h123);
    chk("f20_frame_cnt", {16'd0, smp_fc[0]}, 32'd1);
    send_frame(12'h123, -1, -1, 16, -1, -1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
